// File: rtl/lsp_wb_stage.sv
// Load/store pipe writeback stage: a two-entry result buffer between the memory
// stage and register writeback. Load data is aligned and extended on entry, so
// the buffered entries hold final register values.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   m2w_valid/m2w_ready  input handshake from the memory stage
//   m2w_dst/pc/wb_en     instruction metadata
//   m2w_is_load          selects the aligned load data instead of m2w_result
//   m2w_result           non-load result, stored unmodified
//   m2w_rdata            raw dcache doubleword
//   m2w_addr_lo          load byte offset within the doubleword
//   m2w_size/m2w_sign    load width (byte/half/word/dword) and extension mode
//   lsp_wb_*             head entry toward writeback, valid/ready handshake
module lsp_wb_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m2w_valid,
  output logic        m2w_ready,
  input  logic [4:0]  m2w_dst,
  input  logic [63:0] m2w_pc,
  input  logic        m2w_wb_en,
  input  logic        m2w_is_load,
  input  logic [63:0] m2w_result,
  input  logic [63:0] m2w_rdata,
  input  logic [2:0]  m2w_addr_lo,
  input  logic [1:0]  m2w_size,
  input  logic        m2w_sign,
  output logic [4:0]  lsp_wb_dst,
  output logic [63:0] lsp_wb_result,
  output logic [63:0] lsp_wb_pc,
  output logic        lsp_wb_wb_en,
  output logic        lsp_wb_valid,
  input  logic        lsp_wb_ready
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]  dst;
    logic        wb_en;
    logic [63:0] pc;
    logic [63:0] result;
  } entry_t;

  entry_t          slot_q [2];
  logic            rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic   push, pop;
  logic   wr_ptr;
  logic   [63:0] shifted;
  logic   [63:0] load_val;
  entry_t new_entry;
  entry_t head;

  assign m2w_ready    = (count_q < CntW'(DEPTH));
  assign lsp_wb_valid = (count_q != '0);
  assign push         = m2w_valid && m2w_ready;
  assign pop          = lsp_wb_valid && lsp_wb_ready;
  // Only written with count 0 or 1, so the tail is the head or the other slot.
  assign wr_ptr       = rd_ptr_q ^ count_q[0];

  // Lanes running past bit 63 just pick up the zeros shifted in from the top.
  always_comb begin
    shifted  = m2w_rdata >> {m2w_addr_lo, 3'b000};
    load_val = shifted;
    unique case (m2w_size)
      2'd0: load_val = {{56{m2w_sign & shifted[7]}}, shifted[7:0]};
      2'd1: load_val = {{48{m2w_sign & shifted[15]}}, shifted[15:0]};
      2'd2: load_val = {{32{m2w_sign & shifted[31]}}, shifted[31:0]};
      2'd3: load_val = shifted;
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    new_entry        = '0;
    new_entry.dst    = m2w_dst;
    new_entry.wb_en  = m2w_wb_en && (m2w_dst != 5'd0);
    new_entry.pc     = m2w_pc;
    new_entry.result = m2w_is_load ? load_val : m2w_result;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      rd_ptr_q  <= 1'b0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else begin
      if (push) slot_q[wr_ptr] <= new_entry;
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign head          = slot_q[rd_ptr_q];
  assign lsp_wb_dst    = head.dst;
  assign lsp_wb_result = head.result;
  assign lsp_wb_pc     = head.pc;
  assign lsp_wb_wb_en  = head.wb_en;

endmodule

// File: tb/tb_lsp_wb_stage.sv
module tb_lsp_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        m2w_valid;
  logic        m2w_ready;
  logic [4:0]  m2w_dst;
  logic [63:0] m2w_pc;
  logic        m2w_wb_en;
  logic        m2w_is_load;
  logic [63:0] m2w_result;
  logic [63:0] m2w_rdata;
  logic [2:0]  m2w_addr_lo;
  logic [1:0]  m2w_size;
  logic        m2w_sign;
  logic [4:0]  lsp_wb_dst;
  logic [63:0] lsp_wb_result;
  logic [63:0] lsp_wb_pc;
  logic        lsp_wb_wb_en;
  logic        lsp_wb_valid;
  logic        lsp_wb_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsp_wb_stage #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .m2w_valid     (m2w_valid),
    .m2w_ready     (m2w_ready),
    .m2w_dst       (m2w_dst),
    .m2w_pc        (m2w_pc),
    .m2w_wb_en     (m2w_wb_en),
    .m2w_is_load   (m2w_is_load),
    .m2w_result    (m2w_result),
    .m2w_rdata     (m2w_rdata),
    .m2w_addr_lo   (m2w_addr_lo),
    .m2w_size      (m2w_size),
    .m2w_sign      (m2w_sign),
    .lsp_wb_dst    (lsp_wb_dst),
    .lsp_wb_result (lsp_wb_result),
    .lsp_wb_pc     (lsp_wb_pc),
    .lsp_wb_wb_en  (lsp_wb_wb_en),
    .lsp_wb_valid  (lsp_wb_valid),
    .lsp_wb_ready  (lsp_wb_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [63:0] rdata, input logic [2:0] lo, input logic [1:0] sz,
                          input logic sgn, input logic [4:0] dst, input logic [63:0] pc);
    m2w_is_load = 1'b1;
    m2w_rdata   = rdata;
    m2w_addr_lo = lo;
    m2w_size    = sz;
    m2w_sign    = sgn;
    m2w_dst     = dst;
    m2w_pc      = pc;
    m2w_wb_en   = 1'b1;
    m2w_result  = 64'hDEAD_DEAD_DEAD_DEAD;
  endtask

  task automatic set_alu(input logic [63:0] res, input logic [4:0] dst, input logic wben,
                         input logic [63:0] pc);
    m2w_is_load = 1'b0;
    m2w_result  = res;
    m2w_dst     = dst;
    m2w_wb_en   = wben;
    m2w_pc      = pc;
    m2w_rdata   = 64'hFFFF_FFFF_FFFF_FFFF;
    m2w_addr_lo = 3'd3;
    m2w_size    = 2'd0;
    m2w_sign    = 1'b1;
  endtask

  task automatic push();
    m2w_valid = 1'b1;
    step();
    m2w_valid = 1'b0;
  endtask

  task automatic pop();
    lsp_wb_ready = 1'b1;
    step();
    lsp_wb_ready = 1'b0;
  endtask

  // Single load pushed into an empty buffer, checked, then drained.
  task automatic load_case(input string tag, input logic [63:0] rdata, input logic [2:0] lo,
                           input logic [1:0] sz, input logic sgn, input logic [63:0] exp);
    set_load(rdata, lo, sz, sgn, 5'd9, 64'h40);
    push();
    check({tag, "_valid"}, 64'(lsp_wb_valid), 64'd1);
    check({tag, "_result"}, lsp_wb_result, exp);
    pop();
    check({tag, "_drained"}, 64'(lsp_wb_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; m2w_valid = 1'b0; lsp_wb_ready = 1'b0;
    set_alu(64'h0, 5'd0, 1'b0, 64'h0);
    step(); step();
    check("rst_valid", 64'(lsp_wb_valid), 64'd0);
    check("rst_ready", 64'(m2w_ready), 64'd1);
    check("rst_pc", lsp_wb_pc, 64'd0);
    check("rst_result", lsp_wb_result, 64'd0);
    rst = 1'b0;

    // Pop while empty does nothing.
    pop();
    check("empty_pop_valid", 64'(lsp_wb_valid), 64'd0);
    check("empty_pop_ready", 64'(m2w_ready), 64'd1);

    // Signed byte load, latency 1.
    set_load(64'h0000_0000_0000_8000, 3'd1, 2'd0, 1'b1, 5'd5, 64'h80);
    push();
    check("lb_valid", 64'(lsp_wb_valid), 64'd1);
    check("lb_result", lsp_wb_result, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_wb_en", 64'(lsp_wb_wb_en), 64'd1);
    check("lb_dst", 64'(lsp_wb_dst), 64'd5);
    check("lb_pc", lsp_wb_pc, 64'h80);
    pop();
    check("lb_drained", 64'(lsp_wb_valid), 64'd0);

    load_case("lwu", 64'h8765_4321_DEAD_BEEF, 3'd4, 2'd2, 1'b0, 64'h0000_0000_8765_4321);
    load_case("lw_s", 64'h8765_4321_DEAD_BEEF, 3'd0, 2'd2, 1'b1, 64'hFFFF_FFFF_DEAD_BEEF);
    load_case("lh_mis", 64'hABCD_0000_0000_0000, 3'd7, 2'd1, 1'b1, 64'h0000_0000_0000_00AB);
    load_case("lh_s", 64'h0000_0000_9234_0000, 3'd2, 2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_9234);
    load_case("ld_sgn", 64'h8765_4321_DEAD_BEEF, 3'd0, 2'd3, 1'b1, 64'h8765_4321_DEAD_BEEF);
    load_case("ld_mis", 64'h8765_4321_DEAD_BEEF, 3'd4, 2'd3, 1'b1, 64'h0000_0000_8765_4321);

    // Backpressure: fill both entries, hold, then drain in order.
    set_alu(64'h11, 5'd1, 1'b1, 64'h100);
    push();
    check("bp_ready1", 64'(m2w_ready), 64'd1);
    set_alu(64'h22, 5'd2, 1'b1, 64'h104);
    push();
    check("bp_full_ready", 64'(m2w_ready), 64'd0);
    check("bp_head_pc", lsp_wb_pc, 64'h100);
    // Offered while full: must be ignored.
    set_alu(64'h33, 5'd3, 1'b1, 64'h108);
    m2w_valid = 1'b1;
    step(); step();
    check("bp_hold_pc", lsp_wb_pc, 64'h100);
    check("bp_hold_res", lsp_wb_result, 64'h11);
    check("bp_hold_ready", 64'(m2w_ready), 64'd0);
    m2w_valid = 1'b0;
    lsp_wb_ready = 1'b1;
    step();
    check("bp_pop1_pc", lsp_wb_pc, 64'h104);
    check("bp_pop1_res", lsp_wb_result, 64'h22);
    check("bp_pop1_ready", 64'(m2w_ready), 64'd1);
    step();
    check("bp_pop2_valid", 64'(lsp_wb_valid), 64'd0);
    lsp_wb_ready = 1'b0;

    // Simultaneous push and pop with one entry held.
    set_alu(64'h55, 5'd4, 1'b1, 64'h200);
    push();
    set_alu(64'h66, 5'd6, 1'b1, 64'h204);
    m2w_valid = 1'b1; lsp_wb_ready = 1'b1;
    step();
    m2w_valid = 1'b0; lsp_wb_ready = 1'b0;
    check("pp_valid", 64'(lsp_wb_valid), 64'd1);
    check("pp_pc", lsp_wb_pc, 64'h204);
    check("pp_ready", 64'(m2w_ready), 64'd1);
    pop();
    check("pp_drained", 64'(lsp_wb_valid), 64'd0);

    // x0 destination suppresses writeback.
    set_alu(64'h1234, 5'd0, 1'b1, 64'h300);
    push();
    check("x0_valid", 64'(lsp_wb_valid), 64'd1);
    check("x0_wb_en", 64'(lsp_wb_wb_en), 64'd0);
    check("x0_result", lsp_wb_result, 64'h1234);
    pop();
    set_alu(64'h77, 5'd7, 1'b0, 64'h304);
    push();
    check("nowb_wb_en", 64'(lsp_wb_wb_en), 64'd0);
    check("nowb_dst", 64'(lsp_wb_dst), 64'd7);
    pop();

    // Reset with a full buffer, with a push offered in the same cycle.
    set_alu(64'hAA, 5'd10, 1'b1, 64'h400);
    push();
    set_alu(64'hBB, 5'd11, 1'b1, 64'h404);
    push();
    check("rm_full", 64'(m2w_ready), 64'd0);
    rst = 1'b1; m2w_valid = 1'b1;
    step();
    rst = 1'b0; m2w_valid = 1'b0;
    check("rm_valid", 64'(lsp_wb_valid), 64'd0);
    check("rm_ready", 64'(m2w_ready), 64'd1);
    check("rm_dst", 64'(lsp_wb_dst), 64'd0);
    check("rm_pc", lsp_wb_pc, 64'd0);
    check("rm_result", lsp_wb_result, 64'd0);
    check("rm_wb_en", 64'(lsp_wb_wb_en), 64'd0);
    set_alu(64'hCC, 5'd12, 1'b1, 64'h500);
    push();
    check("post_rst_pc", lsp_wb_pc, 64'h500);
    check("post_rst_ready", 64'(m2w_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
